// File: rtl/j2c_slave.sv
// J2C receive endpoint: synchronises sda/scl, detects start/stop, shifts in
// NBITS data bits LSB-first and strobes each completed word; framing faults pulse frame_err.
module j2c_slave #(
  parameter int unsigned NBITS   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sda,
  input  logic             scl,
  output logic [NBITS-1:0] data,
  output logic             valid,
  output logic             busy,
  output logic             frame_err
);
  localparam int unsigned BW = $clog2(NBITS) + 1;

  typedef enum logic {IDLE, RECV} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_sda_s1, r_sda_s2, r_sda_prev;
  logic             r_scl_s1, r_scl_s2, r_scl_prev;
  logic [BW-1:0]    r_bitcnt;
  logic [NBITS-1:0] r_shift, r_data, w_word;
  logic [7:0]       r_tcnt;
  logic             r_valid, r_err;
  logic             w_start, w_stop, w_rise, w_last, w_tout;
  logic             w_valid_nxt, w_err_nxt;
  logic [BW-2:0]    w_idx;

  assign w_rise  = r_scl_s2 & ~r_scl_prev;
  assign w_start = r_scl_s2 & r_sda_prev & ~r_sda_s2;
  assign w_stop  = r_scl_s2 & ~r_sda_prev & r_sda_s2;
  assign w_last  = w_rise & (r_bitcnt == BW'(NBITS - 1));
  // Timeout fires on the edge at which the counter would reach TIMEOUT.
  assign w_tout  = ~w_rise & (r_tcnt == 8'(TIMEOUT - 1));
  assign w_idx   = r_bitcnt[BW-2:0];

  always_comb begin
    w_word        = r_shift;
    w_word[w_idx] = r_sda_s2;
  end

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_start) w_state_nxt = RECV;
      RECV: begin
        if (w_stop)                    w_state_nxt = IDLE;
        else if (w_start)              w_state_nxt = RECV;
        else if (w_last || w_tout)     w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    if (r_state == RECV) begin
      if (w_stop)       w_err_nxt   = 1'b1;
      else if (w_start) w_err_nxt   = (r_bitcnt != '0);
      else if (w_last)  w_valid_nxt = 1'b1;
      else if (w_tout)  w_err_nxt   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sda_s1   <= 1'b1;
      r_sda_s2   <= 1'b1;
      r_sda_prev <= 1'b1;
      r_scl_s1   <= 1'b1;
      r_scl_s2   <= 1'b1;
      r_scl_prev <= 1'b1;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_tcnt     <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_sda_s1   <= sda;
      r_sda_s2   <= r_sda_s1;
      r_sda_prev <= r_sda_s2;
      r_scl_s1   <= scl;
      r_scl_s2   <= r_scl_s1;
      r_scl_prev <= r_scl_s2;
      r_valid    <= w_valid_nxt;
      r_err      <= w_err_nxt;
      if (w_valid_nxt) r_data <= w_word;
      if (w_start) begin
        r_bitcnt <= '0;
        r_shift  <= '0;
        r_tcnt   <= '0;
      end else if (r_state == RECV && !w_stop) begin
        if (w_rise) begin
          r_shift  <= w_word;
          r_bitcnt <= r_bitcnt + BW'(1);
          r_tcnt   <= '0;
        end else begin
          r_tcnt   <= r_tcnt + 8'd1;
        end
      end
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign busy      = (r_state == RECV);
  assign frame_err = r_err;
endmodule

// File: tb/tb_j2c_slave.sv
// Randomised bench for j2c_slave: pin-level stimulus, a frame-level reference
// model fed by delayed pin history, and literal checks on the directed scenarios.
module tb_j2c_slave;
  localparam int NB = 8;
  localparam int TO = 255;

  logic          clk = 1'b0, rstn = 1'b0, sda = 1'b0, scl = 1'b0;
  logic [NB-1:0] data;
  logic          valid, busy, frame_err;

  j2c_slave #(.NBITS(NB), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .sda(sda), .scl(scl),
    .data(data), .valid(valid), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  int dut_valids = 0, dut_errs = 0, m_nvalid = 0;
  int last_valid_cyc = 0, last_err_cyc = 0, t_rise = 0;
  int lo = 4, hi = 4;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: a pin is seen as an edge 3 clocks after first being sampled.
  bit            ps[4], pc[4];
  bit            m_in, m_valid, m_err, m_ready;
  int            m_nb, m_idle;
  logic [NB-1:0] m_word, m_data;

  always @(posedge clk) begin
    bit cs, prs, cc, prc, st, sp, rise;
    if (!rstn) begin
      for (int i = 0; i < 4; i++) begin ps[i] = 1'b1; pc[i] = 1'b1; end
      m_in = 0; m_nb = 0; m_idle = 0; m_word = '0; m_data = '0;
      m_valid = 0; m_err = 0; m_ready = 1;
    end else begin
      cs = ps[1]; prs = ps[2]; cc = pc[1]; prc = pc[2];
      for (int i = 3; i > 0; i--) begin ps[i] = ps[i-1]; pc[i] = pc[i-1]; end
      ps[0] = sda; pc[0] = scl;
      st   = cc && prs && !cs;
      sp   = cc && !prs && cs;
      rise = cc && !prc;
      m_valid = 0; m_err = 0;
      if (m_in) begin
        if (st) begin
          if (m_nb != 0) m_err = 1;
          m_nb = 0; m_word = '0; m_idle = 0;
        end else if (sp) begin
          m_err = 1; m_in = 0;
        end else if (rise) begin
          m_word[m_nb] = cs; m_nb++; m_idle = 0;
          if (m_nb == NB) begin m_data = m_word; m_valid = 1; m_in = 0; m_nvalid++; end
        end else begin
          m_idle++;
          if (m_idle == TO) begin m_err = 1; m_in = 0; end
        end
      end else if (st) begin
        m_in = 1; m_nb = 0; m_word = '0; m_idle = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      chk("valid", int'(valid), int'(m_valid));
      chk("frame_err", int'(frame_err), int'(m_err));
      chk("busy", int'(busy), int'(m_in));
      chk("data", int'(data), int'(m_data));
      if (valid === 1'b1) begin dut_valids++; last_valid_cyc = cyc; end
      if (frame_err === 1'b1) begin dut_errs++; last_err_cyc = cyc; end
    end
  end

  task automatic wait_clk(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_start();
    scl = 1'b0; wait_clk(lo);
    sda = 1'b1; wait_clk(lo);
    scl = 1'b1; wait_clk(hi);
    sda = 1'b0; wait_clk(hi);
  endtask

  task automatic send_bit(bit b);
    scl = 1'b0; wait_clk(lo / 2);
    sda = b;    wait_clk(lo - lo / 2);
    scl = 1'b1; t_rise = cyc; wait_clk(hi);
  endtask

  task automatic send_bits(logic [NB-1:0] w, int n);
    for (int i = 0; i < n; i++) send_bit(w[i]);
  endtask

  task automatic send_stop();
    scl = 1'b0; wait_clk(lo / 2);
    sda = 1'b0; wait_clk(lo - lo / 2);
    scl = 1'b1; wait_clk(hi);
    sda = 1'b1; wait_clk(hi);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, e0, kind, k;
    logic [NB-1:0] w;

    rstn = 1'b0; sda = 1'b0; scl = 1'b0;
    wait_clk(3);
    chk("rst_data", int'(data), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(frame_err), 0);
    sda = 1'b1; scl = 1'b1;
    wait_clk(1);
    rstn = 1'b1;
    wait_clk(10);
    chk("idle_valids", dut_valids, 0);
    chk("idle_errs", dut_errs, 0);
    chk("idle_busy", int'(busy), 0);

    // single frame 0xA5
    v0 = dut_valids; e0 = dut_errs;
    send_start(); send_bits(8'hA5, NB); wait_clk(4);
    chk("a5_count", dut_valids - v0, 1);
    chk("a5_data", int'(data), 'hA5);
    chk("a5_model", int'(m_data), 'hA5);
    chk("a5_latency", last_valid_cyc - t_rise, 3);
    chk("a5_errs", dut_errs - e0, 0);

    // back-to-back 0x3C, 0xFF
    v0 = dut_valids;
    send_start(); send_bits(8'h3C, NB);
    chk("b2b_first", int'(data), 'h3C);
    send_start(); send_bits(8'hFF, NB); wait_clk(4);
    chk("b2b_second", int'(data), 'hFF);
    chk("b2b_count", dut_valids - v0, 2);

    // stop mid-frame
    v0 = dut_valids; e0 = dut_errs;
    send_start(); send_bits(8'h05, 3); send_stop(); wait_clk(6);
    chk("stop_errs", dut_errs - e0, 1);
    chk("stop_valids", dut_valids - v0, 0);
    chk("stop_data", int'(data), 'hFF);
    chk("stop_busy", int'(busy), 0);

    // repeated start
    v0 = dut_valids; e0 = dut_errs;
    send_start(); send_bits(8'h1B, 5); send_start(); send_bits(8'h81, NB); wait_clk(4);
    chk("rs_errs", dut_errs - e0, 1);
    chk("rs_valids", dut_valids - v0, 1);
    chk("rs_data", int'(data), 'h81);

    // timeout
    e0 = dut_errs;
    send_start(); send_bits(8'h03, 2);
    scl = 1'b0; wait_clk(300);
    chk("to_errs", dut_errs - e0, 1);
    chk("to_delay", last_err_cyc - t_rise, 258);
    chk("to_busy", int'(busy), 0);
    sda = 1'b1; scl = 1'b1; wait_clk(6);

    // reset mid-frame
    e0 = dut_errs;
    send_start(); send_bits(8'h0F, 4);
    rstn = 1'b0; sda = 1'b1; scl = 1'b1;
    wait_clk(3);
    rstn = 1'b1; wait_clk(4);
    chk("rst_mid_errs", dut_errs - e0, 0);
    chk("rst_mid_data", int'(data), 0);
    chk("rst_mid_busy", int'(busy), 0);
    send_start(); send_bits(8'h5A, NB); wait_clk(4);
    chk("rst_mid_5a", int'(data), 'h5A);

    // randomised traffic, checked cycle by cycle against the model
    for (int it = 0; it < 40; it++) begin
      lo = $urandom_range(4, 7); hi = $urandom_range(4, 7);
      kind = $urandom_range(0, 9);
      w = NB'($urandom);
      k = $urandom_range(1, 5);
      if (kind <= 6) begin
        send_start(); send_bits(w, NB);
      end else if (kind == 7) begin
        send_start(); send_bits(w, k); send_stop();
      end else if (kind == 8) begin
        send_start(); send_bits(w, k); send_start(); send_bits(~w, NB);
      end else begin
        send_stop(); wait_clk($urandom_range(0, 12));
      end
    end
    lo = 4; hi = 4;
    wait_clk(10);
    chk("total_valids", dut_valids, m_nvalid);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
